// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchroniser + stability filter giving a clean level and a press pulse.
// Optional auto-repeat of the press pulse while held: define DEBOUNCER_AUTOREPEAT_EN.
module multi_debouncer #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] en
);
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
    if (N_CH < 1 || STABLE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("multi_debouncer: invalid parameters");
    end
    logic [N_CH-1:0] sync [SYNC_STAGES];
    logic [CW-1:0]   cnt  [N_CH];
    logic [N_CH-1:0] s, flip, press;
    assign s     = sync[SYNC_STAGES-1];
    assign press = flip & s;
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CH; i++)
            flip[i] = (s[i] != level[i]) && (cnt[i] == CMAX);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
        end else begin
            sync[0] <= btn;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
    end
    // A terminal count clears the counter together with the level flip, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            level <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= (s[i] == level[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
            level <= level ^ flip;
        end
    end
`ifdef DEBOUNCER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    logic [RW-1:0]   rcnt [N_CH];
    logic [N_CH-1:0] rep, fire;
    // rep selects the period threshold once the first (delayed) repeat has fired.
    always_comb begin
        fire = '0;
        for (int i = 0; i < N_CH; i++)
            fire[i] = level[i] && !flip[i] &&
                      (rcnt[i] == (rep[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) rcnt[i] <= '0;
            rep <= '0;
            en  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                rcnt[i] <= (!level[i] || flip[i] || fire[i]) ? '0 : rcnt[i] + RW'(1);
            rep <= level & ~flip & (rep | fire);
            en  <= press | fire;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) en <= '0;
        else     en <= press;
    end
`endif
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed checks of multi_debouncer with N_CH=3, STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_multi_debouncer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [2:0] level, en;
    int checks = 0;
    int errors = 0;
    int e = 0;
`ifdef DEBOUNCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    multi_debouncer #(
        .N_CH(3), .STABLE_CYCLES(4), .SYNC_STAGES(2), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .level(level), .en(en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: got %b expected %b", tag, e, got, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("reset_level", level, 3'b000);
        chk("reset_en", en, 3'b000);
        rst = 1'b0;
        // clean press on ch0, hold (repeats if enabled), release after edge 20
        btn = 3'b001;
        e = 0;
        for (int n = 0; n < 28; n++) begin
            step();
            chk("press_level", level, {2'b00, e >= 6 && e < 26});
            chk("press_en", en, {2'b00, e == 6 || (AR && (e == 14 || e == 17 || e == 20 || e == 23))});
            if (e == 20) btn = 3'b000;
        end
        // bounce on ch1
        for (int n = 0; n < 6; n++) begin
            btn = (n % 2 == 0) ? 3'b010 : 3'b000;
            step();
            chk("bounce_level", level, 3'b000);
            chk("bounce_en", en, 3'b000);
        end
        btn = 3'b010;
        e = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            chk("bounce_settle_level", level, {1'b0, e >= 6 && e < 14, 1'b0});
            chk("bounce_settle_en", en, {1'b0, e == 6, 1'b0});
            if (e == 8) btn = 3'b000;
        end
        // 3-cycle glitch on ch2
        btn = 3'b100;
        e = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (e == 3) btn = 3'b000;
            chk("glitch_level", level, 3'b000);
            chk("glitch_en", en, 3'b000);
        end
        // ch2 qualifies, ch0 mid-count, then async reset
        btn = 3'b100;
        e = 0;
        for (int n = 0; n < 7; n++) step();
        chk("pre_rst_level", level, 3'b100);
        btn = 3'b101;
        for (int n = 0; n < 3; n++) step();
        rst = 1'b1;
        #1;
        chk("async_rst_level", level, 3'b000);
        chk("async_rst_en", en, 3'b000);
        rst = 1'b0;
        e = 0;
        for (int n = 0; n < 14; n++) begin
            step();
            chk("requal_level", level, (e >= 6 && e < 13) ? 3'b101 : 3'b000);
            chk("requal_en", en, e == 6 ? 3'b101 : 3'b000);
            if (e == 7) btn = 3'b000;
        end
        // simultaneous press
        btn = 3'b111;
        e = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("simul_level", level, e >= 6 ? 3'b111 : 3'b000);
            chk("simul_en", en, e == 6 ? 3'b111 : 3'b000);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
